// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: turns a valid/ready request into a setup -> pulse -> hold
// strobe sequence for one SRAM row, driving write data and capturing preout.
module sram_access_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 1,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic [COLS-1:0] data_in,
  output logic [ROWS-1:0] row_wr,
  output logic [ROWS-1:0] row_rd,
  input  logic [COLS-1:0] preout,
  output logic [COLS-1:0] rd_data,
  output logic            rd_valid,
  output logic            addr_err
);

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0]   S_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0]   P_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0]   H_LAST = CW'(HOLD_CYC - 1);
  localparam logic [ROWS-1:0] ROW0   = ROWS'(1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            ok_q, ok_d;
  logic [COLS-1:0] data_in_q, data_in_d;
  logic [ROWS-1:0] row_wr_q, row_wr_d;
  logic [ROWS-1:0] row_rd_q, row_rd_d;
  logic [COLS-1:0] rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            addr_err_q, addr_err_d;
  logic            req_ready_q, req_ready_d;
  logic            addr_ok;

  // Row range check; only a non-power-of-two row count can see a bad address.
  if (ROWS == (1 << AW)) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_part_range
    assign addr_ok = (req_addr < AW'(ROWS));
  end

  // Phase sequencing plus next values of every registered output. Outputs are
  // derived from the next state so each strobe/flag is a clean flop output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    ok_d       = ok_q;
    data_in_d  = data_in_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    row_wr_d   = '0;
    row_rd_d   = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = SETUP;
          cnt_d      = S_LAST;
          we_d       = req_we;
          addr_d     = req_addr;
          ok_d       = addr_ok;
          addr_err_d = !addr_ok;
          if (req_we) data_in_d = req_wdata;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = P_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = H_LAST;
          if (!we_q) begin
            rd_data_d  = ok_q ? preout : '0;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == PULSE && ok_q) begin
      if (we_q) row_wr_d = ROW0 << addr_q;
      else      row_rd_d = ROW0 << addr_q;
    end

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      ok_q        <= 1'b1;
      data_in_q   <= '0;
      row_wr_q    <= '0;
      row_rd_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      ok_q        <= ok_d;
      data_in_q   <= data_in_d;
      row_wr_q    <= row_wr_d;
      row_rd_q    <= row_rd_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      addr_err_q  <= addr_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign data_in   = data_in_q;
  assign row_wr    = row_wr_q;
  assign row_rd    = row_rd_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: three instances (defaults, ROWS=3, long phases)
// checked every cycle against a cycle-count model, plus literal pins.
module tb_sram_access_ctrl;

  localparam int F_READY = 0, F_DIN = 1, F_RW = 2, F_RR = 3, F_RDD = 4, F_RDV = 5, F_AERR = 6;
  localparam int NPIN_MAX = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_l, valid_l, we_l, wdata_l, pre_l;
  logic [1:0] addr_l [3];
  logic [2:0] ready_l, din_l, rdd_l, rdv_l, aerr_l;
  logic [3:0] rw0, rr0, rw2, rr2;
  logic [2:0] rw1, rr1;
  logic [3:0] rw_l [3];
  logic [3:0] rr_l [3];

  always_comb begin
    rw_l[0] = rw0;
    rw_l[1] = {1'b0, rw1};
    rw_l[2] = rw2;
    rr_l[0] = rr0;
    rr_l[1] = {1'b0, rr1};
    rr_l[2] = rr2;
  end

  sram_access_ctrl #(.ROWS(4)) u_def (
    .clk(clk), .rst(rst_l[0]), .req_valid(valid_l[0]), .req_ready(ready_l[0]),
    .req_we(we_l[0]), .req_addr(addr_l[0]), .req_wdata(wdata_l[0]), .data_in(din_l[0]),
    .row_wr(rw0), .row_rd(rr0), .preout(pre_l[0]), .rd_data(rdd_l[0]),
    .rd_valid(rdv_l[0]), .addr_err(aerr_l[0]));

  sram_access_ctrl #(.ROWS(3)) u_odd (
    .clk(clk), .rst(rst_l[1]), .req_valid(valid_l[1]), .req_ready(ready_l[1]),
    .req_we(we_l[1]), .req_addr(addr_l[1]), .req_wdata(wdata_l[1]), .data_in(din_l[1]),
    .row_wr(rw1), .row_rd(rr1), .preout(pre_l[1]), .rd_data(rdd_l[1]),
    .rd_valid(rdv_l[1]), .addr_err(aerr_l[1]));

  sram_access_ctrl #(.ROWS(4), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_long (
    .clk(clk), .rst(rst_l[2]), .req_valid(valid_l[2]), .req_ready(ready_l[2]),
    .req_we(we_l[2]), .req_addr(addr_l[2]), .req_wdata(wdata_l[2]), .data_in(din_l[2]),
    .row_wr(rw2), .row_rd(rr2), .preout(pre_l[2]), .rd_data(rdd_l[2]),
    .rd_valid(rdv_l[2]), .addr_err(aerr_l[2]));

  function automatic int s_of(int l);    return (l == 2) ? 2 : 1; endfunction
  function automatic int p_of(int l);    return (l == 2) ? 3 : 1; endfunction
  function automatic int h_of(int l);    return (l == 2) ? 2 : 1; endfunction
  function automatic int rows_of(int l); return (l == 1) ? 3 : 4; endfunction

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // preout source: random unless a directed test pins it to a level
  int pre_mode [3];
  always @(posedge clk) begin
    #1;
    for (int l = 0; l < 3; l++) begin
      case (pre_mode[l])
        1:       pre_l[l] = 1'b1;
        2:       pre_l[l] = 1'b0;
        default: pre_l[l] = 1'(($urandom_range(0, 1)));
      endcase
    end
  end

  // Model: k = cycles since the accepting edge (0 = idle). Phase windows follow
  // from S/P/H arithmetic.
  int   k     [3];
  logic m_we  [3];
  logic m_ok  [3];
  logic m_din [3];
  logic m_rdd [3];
  logic [1:0] m_addr [3];

  always @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rst_l[l]) begin
        k[l] <= 0; m_we[l] <= 1'b0; m_ok[l] <= 1'b1; m_din[l] <= 1'b0; m_rdd[l] <= 1'b0;
      end else if (k[l] == 0) begin
        if (valid_l[l]) begin
          k[l]      <= 1;
          m_we[l]   <= we_l[l];
          m_addr[l] <= addr_l[l];
          m_ok[l]   <= (int'(addr_l[l]) < rows_of(l));
          if (we_l[l]) m_din[l] <= wdata_l[l];
        end
      end else begin
        if (!m_we[l] && k[l] == s_of(l) + p_of(l)) m_rdd[l] <= m_ok[l] ? pre_l[l] : 1'b0;
        k[l] <= (k[l] == s_of(l) + p_of(l) + h_of(l)) ? 0 : k[l] + 1;
      end
    end
  end

  function automatic logic [3:0] model_out(int l, int f);
    int s = s_of(l);
    int p = p_of(l);
    int kk = k[l];
    logic [3:0] str;
    str = (kk >= s + 1 && kk <= s + p && m_ok[l]) ? (4'b0001 << m_addr[l]) : 4'b0000;
    case (f)
      F_READY: return {3'b0, kk == 0};
      F_DIN:   return {3'b0, m_din[l]};
      F_RW:    return m_we[l] ? str : 4'b0000;
      F_RR:    return m_we[l] ? 4'b0000 : str;
      F_RDD:   return {3'b0, m_rdd[l]};
      F_RDV:   return {3'b0, (kk == s + p + 1) && !m_we[l]};
      default: return {3'b0, (kk == 1) && !m_ok[l]};
    endcase
  endfunction

  function automatic logic [3:0] dut_out(int l, int f);
    case (f)
      F_READY: return {3'b0, ready_l[l]};
      F_DIN:   return {3'b0, din_l[l]};
      F_RW:    return rw_l[l];
      F_RR:    return rr_l[l];
      F_RDD:   return {3'b0, rdd_l[l]};
      F_RDV:   return {3'b0, rdv_l[l]};
      default: return {3'b0, aerr_l[l]};
    endcase
  endfunction

  function automatic string fname(int f);
    case (f)
      F_READY: return "req_ready";
      F_DIN:   return "data_in";
      F_RW:    return "row_wr";
      F_RR:    return "row_rd";
      F_RDD:   return "rd_data";
      F_RDV:   return "rd_valid";
      default: return "addr_err";
    endcase
  endfunction

  // Literal expectations posted by the directed sequence (absolute cycle).
  int         pin_cyc  [NPIN_MAX];
  int         pin_lane [NPIN_MAX];
  int         pin_fld  [NPIN_MAX];
  logic [3:0] pin_val  [NPIN_MAX];
  int         npin = 0;
  int unsigned base = 0;
  logic chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int l, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane=%0d cyc=%0d actual=%h expected=%h", nm, l, cyc, act, exp);
    end
  endtask

  logic [3:0] prev_str [3];
  logic       prev_din [3];

  // Single compare process: model, invariants and pins, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < 3; l++) begin
        for (int f = 0; f < 7; f++) chk(fname(f), l, dut_out(l, f), model_out(l, f));
        chk("no_overlap", l, {3'b0, (rw_l[l] != 4'b0) && (rr_l[l] != 4'b0)}, 4'd0);
        chk("onehot0", l, {3'b0, $onehot0(rw_l[l]) && $onehot0(rr_l[l])}, 4'd1);
        if (prev_str[l] == 4'b0 && (rw_l[l] | rr_l[l]) != 4'b0)
          chk("din_stable_at_rise", l, {3'b0, din_l[l]}, {3'b0, prev_din[l]});
        prev_str[l] <= rw_l[l] | rr_l[l];
        prev_din[l] <= din_l[l];
      end
      for (int i = 0; i < npin; i++)
        if (pin_cyc[i] == int'(cyc))
          chk({"pin_", fname(pin_fld[i])}, pin_lane[i], dut_out(pin_lane[i], pin_fld[i]), pin_val[i]);
    end
  end

  // Expect field f of lane l to equal v in cycle n after the latest accept.
  task automatic pin(input int n, input int l, input int f, input logic [3:0] v);
    if (npin < NPIN_MAX) begin
      pin_cyc[npin]  = int'(base) + n - 1;
      pin_lane[npin] = l;
      pin_fld[npin]  = f;
      pin_val[npin]  = v;
      npin++;
    end
  endtask

  // Present a request and hold it until the edge that accepts it; returns
  // 1 time unit into cycle 1 with base set to that cycle.
  task automatic issue(input int l, input logic we, input logic [1:0] a, input logic d);
    logic done = 1'b0;
    valid_l[l] = 1'b1; we_l[l] = we; addr_l[l] = a; wdata_l[l] = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ready_l[l] && !rst_l[l]) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      $display("FAIL issue_timeout lane=%0d actual=no_accept expected=accept_within_100", l);
      $fatal(1, "request never accepted");
    end
    base = cyc;
  endtask

  task automatic idle(input int l, input int n);
    valid_l[l] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_l = 3'b111; valid_l = '0; we_l = '0; wdata_l = '0;
    for (int l = 0; l < 3; l++) begin addr_l[l] = '0; pre_mode[l] = 0; end
    repeat (3) @(posedge clk);
    #1;
    rst_l = '0;
    chk_en = 1'b1;
    base = cyc;
    for (int l = 0; l < 3; l++) begin
      pin(1, l, F_READY, 4'd1); pin(1, l, F_DIN, 4'd0); pin(1, l, F_RDD, 4'd0);
      pin(1, l, F_RW, 4'd0);    pin(1, l, F_RDV, 4'd0);
    end
    idle(0, 2);

    // default write row 2
    issue(0, 1'b1, 2'd2, 1'b1); valid_l[0] = 1'b0;
    pin(1, 0, F_DIN, 4'd1); pin(1, 0, F_RW, 4'd0); pin(2, 0, F_RW, 4'b0100);
    pin(3, 0, F_RW, 4'd0);  pin(3, 0, F_READY, 4'd0); pin(4, 0, F_READY, 4'd1);
    idle(0, 4);

    // default reads of row 2 with preout forced high, then low
    pre_mode[0] = 1;
    issue(0, 1'b0, 2'd2, 1'b0); valid_l[0] = 1'b0;
    pin(2, 0, F_RR, 4'b0100); pin(2, 0, F_RDV, 4'd0); pin(3, 0, F_RDD, 4'd1);
    pin(3, 0, F_RDV, 4'd1);   pin(4, 0, F_RDV, 4'd0);
    idle(0, 4);
    pre_mode[0] = 2;
    issue(0, 1'b0, 2'd2, 1'b0); valid_l[0] = 1'b0;
    pin(3, 0, F_RDD, 4'd0); pin(3, 0, F_RDV, 4'd1);
    idle(0, 4);
    pre_mode[0] = 0;

    // long phases: write then read row 0 back to back
    pre_mode[2] = 1;
    issue(2, 1'b1, 2'd0, 1'b1);
    pin(2, 2, F_RW, 4'd0); pin(3, 2, F_RW, 4'd1); pin(4, 2, F_RW, 4'd1);
    pin(5, 2, F_RW, 4'd1); pin(6, 2, F_RW, 4'd0);
    pin(7, 2, F_READY, 4'd0); pin(8, 2, F_READY, 4'd1);
    issue(2, 1'b0, 2'd0, 1'b0); valid_l[2] = 1'b0;
    pin(3, 2, F_RR, 4'd1); pin(5, 2, F_RR, 4'd1); pin(6, 2, F_RR, 4'd0);
    pin(5, 2, F_RDV, 4'd0); pin(6, 2, F_RDV, 4'd1); pin(6, 2, F_RDD, 4'd1);
    pin(7, 2, F_RDV, 4'd0); pin(8, 2, F_READY, 4'd1);
    idle(2, 8);
    pre_mode[2] = 0;

    // continuous alternating requests at defaults
    for (int i = 0; i < 8; i++) begin
      issue(0, (i % 2) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      pin(3, 0, F_READY, 4'd0); pin(4, 0, F_READY, 4'd1);
    end
    idle(0, 4);

    // reset during the pulse of a read, then a normal write
    pre_mode[0] = 1;
    issue(0, 1'b0, 2'd1, 1'b0); valid_l[0] = 1'b0;
    pin(2, 0, F_RR, 4'b0010);
    @(posedge clk); #1; rst_l[0] = 1'b1;
    @(posedge clk); #1; rst_l[0] = 1'b0;
    pin(3, 0, F_RR, 4'd0); pin(3, 0, F_RDV, 4'd0); pin(3, 0, F_READY, 4'd1);
    pin(3, 0, F_DIN, 4'd0); pin(3, 0, F_RDD, 4'd0);
    issue(0, 1'b1, 2'd3, 1'b1); valid_l[0] = 1'b0;
    pin(1, 0, F_DIN, 4'd1); pin(2, 0, F_RW, 4'b1000);
    idle(0, 4);
    pre_mode[0] = 0;

    // ROWS=3: valid read leaves rd_data=1, then out-of-range read clears it
    pre_mode[1] = 1;
    issue(1, 1'b0, 2'd1, 1'b0); valid_l[1] = 1'b0;
    pin(3, 1, F_RDD, 4'd1);
    idle(1, 4);
    issue(1, 1'b0, 2'd3, 1'b0); valid_l[1] = 1'b0;
    pin(1, 1, F_AERR, 4'd1); pin(2, 1, F_AERR, 4'd0); pin(2, 1, F_RR, 4'd0);
    pin(3, 1, F_RDD, 4'd0);  pin(3, 1, F_RDV, 4'd1);  pin(4, 1, F_READY, 4'd1);
    idle(1, 4);
    pre_mode[1] = 0;

    // randomized traffic per lane, with occasional resets on lane 0
    for (int l = 0; l < 3; l++) begin
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 2) == 0) idle(l, $urandom_range(1, 3));
        issue(l, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) valid_l[l] = 1'b0;
        if (l == 0 && (n % 7) == 3) begin
          valid_l[0] = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rst_l[0] = 1'b1;
          @(posedge clk); #1;
          rst_l[0] = 1'b0;
        end
      end
      idle(l, 10);
    end

    idle(0, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
